// File: rtl/fir_cap_wr_if.sv
// Capture-writer bus: frame control and sample input from the filter side,
// RAM write port and status back from the capture block.
interface fir_cap_wr_if #(
  parameter int DW = 16,
  parameter int AW = 12
);
  logic          start;
  logic          stop;
  logic [2:0]    len_sel;
  logic [DW-1:0] din;
  logic          din_vld;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_cnt;

  modport master (
    output start, stop, len_sel, din, din_vld,
    input  wr_en, wr_addr, wr_data, busy, done, wr_cnt
  );

  modport slave (
    input  start, stop, len_sel, din, din_vld,
    output wr_en, wr_addr, wr_data, busy, done, wr_cnt
  );
endinterface

// File: rtl/fir_cap_wr.sv
// Frame capture writer: stores a run of filtered samples into RAM, one frame per start.
// Define CAP_RING_EN to turn the frame into a circular buffer that fills until stop.
module fir_cap_wr #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  fir_cap_wr_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          done_q, done_d;

  logic [AW-1:0] last_addr;
  logic          last_hit;
  logic          start_frame;
  logic          write_go;

  function automatic logic [AW:0] len_of(input logic [2:0] sel);
    case (sel)
      3'd0:    len_of = (AW+1)'(64);
      3'd1:    len_of = (AW+1)'(128);
      3'd2:    len_of = (AW+1)'(512);
      3'd3:    len_of = (AW+1)'(2048);
      default: len_of = (AW+1)'(4096);
    endcase
  endfunction

  assign last_addr   = AW'(len_q - (AW+1)'(1));
  assign last_hit    = (addr_q == last_addr);
  // stop always outranks start and any pending sample
  assign start_frame = bus.start && !bus.stop && (state_q == IDLE || state_q == DONE);
  assign write_go    = (state_q == FILL) && !bus.stop && bus.din_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= (AW+1)'(64);
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_frame) state_d = ARM;
      ARM:  state_d = bus.stop ? IDLE : FILL;
      FILL: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.din_vld && last_hit) begin
`ifdef CAP_RING_EN
          state_d = FILL;
`else
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        if (bus.stop)        state_d = IDLE;
        else if (start_frame) state_d = ARM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    len_d     = len_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (start_frame) begin
      len_d  = len_of(bus.len_sel);
      addr_d = '0;
      cnt_d  = '0;
    end

    if (write_go) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = bus.din;
      if (cnt_q != len_q) cnt_d = cnt_q + (AW+1)'(1);
      if (!last_hit) begin
        addr_d = addr_q + AW'(1);
      end else begin
`ifdef CAP_RING_EN
        addr_d = '0;
`else
        addr_d = addr_q;
`endif
      end
    end

`ifdef CAP_RING_EN
    // one-cycle pulse on every completed pass through the buffer
    done_d = write_go && last_hit;
`else
    done_d = (state_d == DONE);
`endif
  end

  assign bus.busy    = (state_q == ARM) || (state_q == FILL);
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_cnt  = cnt_q;

endmodule

// File: tb/tb_fir_cap_wr.sv
// Directed bench for fir_cap_wr: frame fill, gapped fill, abort/restart, and
// start/stop collision plus reset mid-frame.
module tb_fir_cap_wr;
  localparam int DW = 16;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  fir_cap_wr_if #(.DW(DW), .AW(AW)) bus ();

  fir_cap_wr #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int n;
    int ndone;
    bus.start = 0; bus.stop = 0; bus.len_sel = 0; bus.din = 0; bus.din_vld = 0;

    // reset state
    tick(); tick();
    check("rst_wr_en", 32'(bus.wr_en), 0);
    check("rst_wr_addr", 32'(bus.wr_addr), 0);
    check("rst_wr_data", 32'(bus.wr_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_wr_cnt", 32'(bus.wr_cnt), 0);
    rst_n = 1;
    tick();

    // 64-word frame, continuous samples
    bus.len_sel = 3'd0; bus.start = 1; tick(); bus.start = 0;
    check("arm_busy", 32'(bus.busy), 1);
    check("arm_cnt", 32'(bus.wr_cnt), 0);
    bus.din_vld = 1; bus.din = 16'hBEEF; tick();
    check("arm_discard", 32'(bus.wr_en), 0);
`ifdef CAP_RING_EN
    ndone = 0;
    for (int i = 0; i < 200; i++) begin
      bus.din = DW'(i); tick();
      check("ring_en", 32'(bus.wr_en), 1);
      check("ring_addr", 32'(bus.wr_addr), 32'(i % 64));
      check("ring_data", 32'(bus.wr_data), 32'(i));
      check("ring_cnt", 32'(bus.wr_cnt), (i + 1 < 64) ? 32'(i + 1) : 32'd64);
      if (bus.done) ndone++;
    end
    check("ring_done_pulses", 32'(ndone), 3);
    bus.din_vld = 0; bus.stop = 1; tick(); bus.stop = 0;
    check("ring_stop_busy", 32'(bus.busy), 0);
`else
    for (int i = 0; i < 64; i++) begin
      bus.din = DW'(i); tick();
      check("f64_en", 32'(bus.wr_en), 1);
      check("f64_addr", 32'(bus.wr_addr), 32'(i));
      check("f64_data", 32'(bus.wr_data), 32'(i));
      check("f64_cnt", 32'(bus.wr_cnt), 32'(i + 1));
    end
    check("f64_done", 32'(bus.done), 1);
    check("f64_busy", 32'(bus.busy), 0);
    bus.din = 16'd64; tick();
    check("f64_no65", 32'(bus.wr_en), 0);
    check("f64_done_hold", 32'(bus.done), 1);
    check("f64_cnt_final", 32'(bus.wr_cnt), 64);
    bus.din_vld = 0;
`endif

    // 4096-word frame, din_vld toggling; len_sel change after latch ignored
    bus.len_sel = 3'd4; bus.start = 1; tick(); bus.start = 0; bus.len_sel = 3'd0;
    check("f4k_done_clr", 32'(bus.done), 0);
    check("f4k_busy", 32'(bus.busy), 1);
    bus.din_vld = 0; tick();
    n = 0;
    for (int k = 0; k < 8192; k++) begin
      bus.din_vld = (k % 2 == 0);
      bus.din = DW'(k);
      tick();
      check("f4k_mirror", 32'(bus.wr_en), 32'(k % 2 == 0));
      if (k % 2 == 0) begin
        check("f4k_addr", 32'(bus.wr_addr), 32'(n));
        check("f4k_data", 32'(bus.wr_data), 32'(k & 16'hFFFF));
        n++;
      end
    end
    check("f4k_writes", 32'(n), 4096);
    check("f4k_cnt", 32'(bus.wr_cnt), 4096);
`ifdef CAP_RING_EN
    bus.din_vld = 0; bus.stop = 1; tick(); bus.stop = 0;
`else
    check("f4k_done", 32'(bus.done), 1);
`endif

    // 128-word frame aborted after 40 writes; start mid-fill ignored
    bus.len_sel = 3'd1; bus.start = 1; tick(); bus.start = 0;
    bus.din_vld = 0; tick();
    for (int i = 0; i < 40; i++) begin
      bus.din_vld = 1; bus.din = DW'(i + 100); bus.start = (i == 20);
      tick();
      check("abort_addr", 32'(bus.wr_addr), 32'(i));
      check("abort_data", 32'(bus.wr_data), 32'(i + 100));
    end
    bus.start = 0;
    bus.stop = 1; bus.din = 16'd999; tick(); bus.stop = 0;
    check("abort_no_wr", 32'(bus.wr_en), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_cnt", 32'(bus.wr_cnt), 40);
    bus.din_vld = 0; tick();
    check("abort_cnt_hold", 32'(bus.wr_cnt), 40);
    bus.len_sel = 3'd0; bus.start = 1; tick(); bus.start = 0;
    check("restart_cnt", 32'(bus.wr_cnt), 0);
    bus.din_vld = 1; bus.din = 16'd7; tick();
    bus.din = 16'd8; tick();
    check("restart_en", 32'(bus.wr_en), 1);
    check("restart_addr", 32'(bus.wr_addr), 0);
    check("restart_data", 32'(bus.wr_data), 8);
    bus.din_vld = 0; bus.stop = 1; tick(); bus.stop = 0;

    // start and stop together from IDLE
    bus.start = 1; bus.stop = 1; tick(); bus.start = 0; bus.stop = 0;
    check("coll_busy", 32'(bus.busy), 0);
    tick();
    check("coll_busy2", 32'(bus.busy), 0);

    // reset at write 100 of a 512-word frame
    bus.len_sel = 3'd2; bus.start = 1; tick(); bus.start = 0;
    bus.din_vld = 0; tick();
    for (int i = 0; i < 100; i++) begin
      bus.din_vld = 1; bus.din = DW'(i + 1); tick();
      check("r512_addr", 32'(bus.wr_addr), 32'(i));
    end
    bus.din = 16'd500;
    #2 rst_n = 0; #1;
    check("rstmid_wr_en", 32'(bus.wr_en), 0);
    check("rstmid_wr_addr", 32'(bus.wr_addr), 0);
    check("rstmid_wr_data", 32'(bus.wr_data), 0);
    check("rstmid_busy", 32'(bus.busy), 0);
    check("rstmid_done", 32'(bus.done), 0);
    check("rstmid_cnt", 32'(bus.wr_cnt), 0);
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_wr", 32'(bus.wr_en), 0);
      check("post_rst_busy", 32'(bus.busy), 0);
    end
    bus.din_vld = 0; bus.len_sel = 3'd0; bus.start = 1; tick(); bus.start = 0;
    bus.din_vld = 1; bus.din = 16'h0011; tick();
    bus.din = 16'h0022; tick();
    check("post_rst_en", 32'(bus.wr_en), 1);
    check("post_rst_addr", 32'(bus.wr_addr), 0);
    check("post_rst_data", 32'(bus.wr_data), 32'h22);
    bus.din_vld = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
